// File: rtl/rgb_frame_streamer_if.sv
// Pixel stream interface for rgb_frame_streamer.
// Carries one RGB pixel per valid/ready handshake, plus frame/line markers.
//   px_valid  source -> sink  pixel available
//   px_ready  sink -> source  sink accepts pixel
//   px_r/g/b  source -> sink  colour channels, CW bits each
//   px_sof    source -> sink  first pixel of frame
//   px_eol    source -> sink  last pixel of a line
//   px_eof    source -> sink  last pixel of frame
interface rgb_frame_streamer_if #(
  parameter int CW = 8
) ();
  logic          px_valid;
  logic          px_ready;
  logic [CW-1:0] px_r;
  logic [CW-1:0] px_g;
  logic [CW-1:0] px_b;
  logic          px_sof;
  logic          px_eol;
  logic          px_eof;

  modport master (
    output px_valid, px_r, px_g, px_b, px_sof, px_eol, px_eof,
    input  px_ready
  );

  modport slave (
    input  px_valid, px_r, px_g, px_b, px_sof, px_eol, px_eof,
    output px_ready
  );
endinterface

// File: rtl/rgb_frame_streamer.sv
// Frame source: reads a width x height RGB frame from a pixel memory with
// one-cycle read latency and emits it in raster order on a valid/ready stream.
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle frame request, ignored while busy
//   width, height   frame size, sampled when start is accepted
//   busy, done      frame in progress / one-cycle completion pulse
//   mem_rd          memory read strobe
//   mem_addr        linear pixel address y*width+x
//   mem_data        {R,G,B}, valid the cycle after mem_rd
//   px              pixel stream (master side)
module rgb_frame_streamer #(
  parameter int XW = 11,
  parameter int YW = 11,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [XW-1:0]        width,
  input  logic [YW-1:0]        height,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd,
  output logic [XW+YW-1:0]     mem_addr,
  input  logic [3*CW-1:0]      mem_data,
  rgb_frame_streamer_if.master px
);

  localparam int AW = XW + YW;
  localparam int EW = 3 * CW + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   width_q, x_q;
  logic [YW-1:0]   height_q, y_q;
  logic [AW-1:0]   addr_q;
  logic            inflight_q;
  logic [2:0]      meta_q;        // {sof,eol,eof} of the read in flight
  logic [EW-1:0]   fifo_q [2];
  logic            wr_q, rd_q;
  logic [1:0]      count_q;
  logic            done_q, done_d;

  logic            x_last, y_last;
  logic            push, pop;
  logic [EW-1:0]   head;
  logic [2:0]      occ;

  assign head         = fifo_q[rd_q];
  assign px.px_valid  = (count_q != 2'd0);
  assign {px.px_r, px.px_g, px.px_b, px.px_sof, px.px_eol, px.px_eof} = head;

  assign pop    = px.px_valid & px.px_ready;
  assign push   = inflight_q;
  assign x_last = (x_q == width_q - XW'(1));
  assign y_last = (y_q == height_q - YW'(1));
  // Occupancy the FIFO will see once the in-flight read lands, net of this cycle's pop.
  assign occ    = 3'(count_q) + 3'(inflight_q) - 3'(pop);

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign mem_addr = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mem_rd  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (width != '0 && height != '0) begin
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        mem_rd = (occ < 3'd2);
        if (mem_rd && x_last && y_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head[0]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      width_q    <= '0;
      height_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      meta_q     <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      count_q    <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (state_q == IDLE && start) begin
        width_q  <= width;
        height_q <= height;
        x_q      <= '0;
        y_q      <= '0;
        addr_q   <= '0;
      end else if (mem_rd) begin
        addr_q <= addr_q + AW'(1);
        meta_q <= {(x_q == '0) && (y_q == '0), x_last, x_last && y_last};
        if (x_last) begin
          x_q <= '0;
          y_q <= y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end

      inflight_q <= mem_rd;

      if (push) begin
        fifo_q[wr_q] <= {mem_data, meta_q};
        wr_q         <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
